aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Round-level sequencer directly upstream of the 21-cycle per-round cycle FSM.
//  - Accepts a block from the host with a valid/ready handshake.
//  - Pulses datapath load, then issues a start to the cycle FSM.
//  - Counts rounds and drives the last-round flag and the key-schedule Rcon byte.
//  - Signals completion to the host.
// PARAMETERS
//  NUM_ROUNDS   10     rounds per block; legal range 1..14 (10 = AES-128)
//  RCON_INIT    8'h01  Rcon value for round 1
// PORTS
//  ClkxCI        in   1  clock, rising edge
//  RstxBI        in   1  reset, asynchronous, active-low
//  InValidxSI    in   1  host offers plaintext/key
//  InReadyxSO    out  1  ctrl can accept a block (high only in IDLE)
//  LoadxSO       out  1  1-cycle pulse: datapath captures plaintext/key
//  StartxSO      out  1  start to cycle FSM (its StartxSI)
//  IdlexSI       in   1  cycle FSM is in its idle state
//  ShiftRowsxSI  in   1  cycle FSM in final cycle of a round (state 21)
//  LastRoundxSO  out  1  current round == NUM_ROUNDS (cycle FSM LastRoundxSI)
//  RoundxDO      out  4  current round number, 1..NUM_ROUNDS; 0 when idle
//  RconxDO       out  8  Rcon for current round's key schedule
//  BusyxSO       out  1  block in flight (LOAD, START, RUN)
//  DonexSO       out  1  ciphertext valid at datapath output
//  OutAckxSI     in   1  host consumed result (used only with AES_DONE_HOLD_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, RoundxDO=0, RconxDO=8'h00, all 1-bit outputs 0 except
//    InReadyxSO=1 (combinational from IDLE).
//  - FSM states and transitions:
//    - IDLE: InReadyxSO=1. InValidxSI=1 -> LOAD.
//    - LOAD: LoadxSO=1 for exactly one cycle -> START.
//    - START: RoundxDO=1, RconxDO=RCON_INIT. StartxSO=IdlexSI.
//      IdlexSI=1 -> RUN; otherwise wait in START.
//    - RUN: on ShiftRowsxSI=1:
//      - round<NUM_ROUNDS: round+=1, Rcon=xtime(Rcon) (shift left; XOR 8'h1B if
//        bit7 was set). Sequence 01,02,04,08,10,20,40,80,1B,36.
//      - round==NUM_ROUNDS: -> DONE.
//    - DONE: DonexSO=1; RoundxDO/RconxDO hold their last values; -> IDLE (see
//      CONFIGURATION).
//  - LastRoundxSO: combinational, (state==RUN || state==START) &&
//    RoundxDO==NUM_ROUNDS. Valid in the same cycle as ShiftRowsxSI so the cycle FSM
//    branches to idle.
//  - Entry to IDLE: RoundxDO and RconxDO are cleared to 0.
//  - Latency (NUM_ROUNDS=10): handshake accepted in cycle 0; LOAD cycle 1;
//    START cycle 2; cycle FSM state 1 at cycle 3; final ShiftRowsxSI at cycle 212;
//    DonexSO in cycle 213.
//  - Boundaries:
//    - ShiftRowsxSI outside RUN is ignored.
//    - InValidxSI outside IDLE is ignored; the host must hold it until
//      InReadyxSO is seen.
//    - Round counter never exceeds NUM_ROUNDS. Illegal state encodings -> IDLE.
//    - RstxBI low mid-block aborts immediately. Same reset as the cycle FSM, so
//      both restart in idle together.
// CONFIGURATION
//  AES_DONE_HOLD_EN
//   - Defined: DONE holds DonexSO=1 until OutAckxSI=1, then -> IDLE next cycle.
//     InReadyxSO stays 0 while in DONE.
//   - Undefined: DonexSO is a 1-cycle pulse; OutAckxSI is unused; DONE -> IDLE
//     unconditionally.
// STRUCTURE
//  - Shared package aes_pkg: round-ctrl state encodings (IDLE, LOAD, START, RUN,
//    DONE; 3-bit), AES_NUM_ROUNDS_128=10, AES_RCON_INIT=8'h01,
//    AES_RCON_POLY=8'h1B.
//  - Sub-module aes_rcon_gen: combinational xtime step, 8-bit in, 8-bit out.
//    Shared later with the key-expansion block.
// TESTING (bench instantiates this block plus the 21-cycle cycle FSM)
//  1. Reset, then idle 5 cycles -> InReadyxSO=1, RoundxDO=0, RconxDO=00,
//     no LoadxSO/StartxSO.
//  2. InValidxSI=1 at cycle 0 -> LoadxSO@1, StartxSO@2, DonexSO@213.
//     RconxDO per round: 01,02,04,08,10,20,40,80,1B,36.
//  3. LastRoundxSO high only during round 10 (cycles 192..212); cycle FSM
//     returns to idle, not state 1.
//  4. AES_DONE_HOLD_EN: delay OutAckxSI 7 cycles -> DonexSO high 8 cycles,
//     InReadyxSO=0 throughout, IDLE the cycle after ack.
//  5. RstxBI low at cycle 100 (round 5) -> all outputs at reset values
//     asynchronously; new block afterwards completes with full 213-cycle latency.
//  6. NUM_ROUNDS=1 and back-to-back InValidxSI -> single round, Done at 24;
//     second block accepted only after IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES package: round-control state encodings and round/Rcon constants.
// Used by the round controller now and by the key-expansion block later.
package aes_pkg;

    // Round-controller states, 3-bit encoding; unused codes fall back to IDLE
    typedef enum logic [2:0] {
        RC_IDLE  = 3'd0,
        RC_LOAD  = 3'd1,
        RC_START = 3'd2,
        RC_RUN   = 3'd3,
        RC_DONE  = 3'd4
    } rc_state_e;

    localparam int unsigned AES_NUM_ROUNDS_128 = 10;
    localparam logic [7:0]  AES_RCON_INIT      = 8'h01;
    // Reduction constant of x^8 + x^4 + x^3 + x + 1 after dropping x^8
    localparam logic [7:0]  AES_RCON_POLY      = 8'h1B;

endpackage

// File: rtl/aes_rcon_gen.sv
// Combinational xtime step for the key-schedule round constant:
// multiply by x in GF(2^8), reducing with AES_RCON_POLY on overflow.
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic [7:0] rcon_i,
    output logic [7:0] rcon_o
);

    // Shift left one bit; fold the carried-out bit back in via the polynomial
    always_comb begin
        rcon_o = {rcon_i[6:0], 1'b0};
        if (rcon_i[7]) begin
            rcon_o = rcon_o ^ AES_RCON_POLY;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Round-level sequencer sitting in front of the 21-cycle per-round cycle FSM.
// Takes a block from the host, pulses the datapath load, starts the cycle FSM,
// counts rounds (round number, last-round flag, key-schedule Rcon) and reports
// completion.
// Build option: define AES_DONE_HOLD_EN to hold DonexSO until the host acks
// with OutAckxSI; without it DonexSO is a single-cycle pulse.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS_128,
    parameter logic [7:0]  RCON_INIT  = AES_RCON_INIT
) (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       InValidxSI,
    output logic       InReadyxSO,
    output logic       LoadxSO,
    output logic       StartxSO,
    input  logic       IdlexSI,
    input  logic       ShiftRowsxSI,
    output logic       LastRoundxSO,
    output logic [3:0] RoundxDO,
    output logic [7:0] RconxDO,
    output logic       BusyxSO,
    output logic       DonexSO,
    input  logic       OutAckxSI
);

    // Round number fits in 4 bits for the whole legal range 1..14
    localparam logic [3:0] ROUND_MAX = 4'(NUM_ROUNDS);

    rc_state_e  state_q;
    logic [3:0] round_q;
    logic [3:0] round_d;
    logic [7:0] rcon_q;
    logic [7:0] rcon_d;
    logic       load_q;
    logic       busy_q;
    logic       done_q;

`ifndef AES_DONE_HOLD_EN
    // The ack only matters when DONE waits for the host
    logic unused_ack;
    assign unused_ack = OutAckxSI;
`endif

    // Next round's Rcon; same xtime block the key expansion will reuse
    aes_rcon_gen u_rcon_gen (
        .rcon_i (rcon_q),
        .rcon_o (rcon_d)
    );

    assign round_d = round_q + 4'd1;

    // Sequencer: state, round counter, Rcon and the registered pulses/flags.
    // Round/Rcon are cleared on every entry to IDLE and held through DONE.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q <= RC_IDLE;
            round_q <= '0;
            rcon_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                RC_IDLE: begin
                    if (InValidxSI) begin
                        state_q <= RC_LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RC_LOAD: begin
                    state_q <= RC_START;
                    round_q <= 4'd1;
                    rcon_q  <= RCON_INIT;
                end
                RC_START: begin
                    // Start is only taken once the cycle FSM sits in idle
                    if (IdlexSI) begin
                        state_q <= RC_RUN;
                    end
                end
                RC_RUN: begin
                    // ShiftRowsxSI marks the last cycle of the current round
                    if (ShiftRowsxSI) begin
                        if (round_q < ROUND_MAX) begin
                            round_q <= round_d;
                            rcon_q  <= rcon_d;
                        end else begin
                            state_q <= RC_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RC_DONE: begin
`ifdef AES_DONE_HOLD_EN
                    if (OutAckxSI) begin
                        state_q <= RC_IDLE;
                        round_q <= '0;
                        rcon_q  <= '0;
                    end else begin
                        done_q  <= 1'b1;
                    end
`else
                    state_q <= RC_IDLE;
                    round_q <= '0;
                    rcon_q  <= '0;
`endif
                end
                default: begin
                    state_q <= RC_IDLE;
                    round_q <= '0;
                    rcon_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Host and cycle-FSM facing decode of the current state
    always_comb begin
        InReadyxSO   = (state_q == RC_IDLE);
        StartxSO     = (state_q == RC_START) && IdlexSI;
        // Must be valid alongside ShiftRowsxSI so the cycle FSM returns to idle;
        // START is included so single-round builds flag the last round up front
        LastRoundxSO = ((state_q == RC_RUN) || (state_q == RC_START)) &&
                       (round_q == ROUND_MAX);
    end

    assign LoadxSO  = load_q;
    assign BusyxSO  = busy_q;
    assign DonexSO  = done_q;
    assign RoundxDO = round_q;
    assign RconxDO  = rcon_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl driven against a behavioural model of the
// 21-cycle per-round cycle FSM. Cycle k is sampled 1 time unit after the k-th
// rising edge following the one that saw the handshake set up.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

`ifdef AES_DONE_HOLD_EN
    localparam int DONE_LAST = 220;   // ack raised 7 cycles after DonexSO rises
`else
    localparam int DONE_LAST = 213;
`endif

    logic ClkxCI = 1'b0;
    logic RstxBI = 1'b0;
    always #5 ClkxCI = ~ClkxCI;

    int nassert = 0;
    int nfail   = 0;

    logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // ---------------- DUT 1: NUM_ROUNDS = 10 ----------------
    logic       in_valid = 1'b0, out_ack = 1'b0, sr_force = 1'b0;
    logic       in_ready, load, start, last, busy, done, idle, sr;
    logic [3:0] round;
    logic [7:0] rcon;
    int         cs;

    assign idle = (cs == 0);
    assign sr   = (cs == 21) || sr_force;

    always @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI)         cs <= 0;
        else if (cs == 0)    cs <= start ? 1 : 0;
        else if (cs == 21)   cs <= last ? 0 : 1;
        else                 cs <= cs + 1;
    end

    aes_round_ctrl #(.NUM_ROUNDS(10), .RCON_INIT(8'h01)) dut (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .InValidxSI(in_valid), .InReadyxSO(in_ready),
        .LoadxSO(load), .StartxSO(start), .IdlexSI(idle), .ShiftRowsxSI(sr),
        .LastRoundxSO(last), .RoundxDO(round), .RconxDO(rcon), .BusyxSO(busy),
        .DonexSO(done), .OutAckxSI(out_ack)
    );

    // ---------------- DUT 2: NUM_ROUNDS = 1 ----------------
    logic       in_valid2 = 1'b0;
    logic       out_ack2  = 1'b1;
    logic       in_ready2, load2, start2, last2, busy2, done2, idle2, sr2;
    logic [3:0] round2;
    logic [7:0] rcon2;
    int         cs2;

    assign idle2 = (cs2 == 0);
    assign sr2   = (cs2 == 21);

    always @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI)         cs2 <= 0;
        else if (cs2 == 0)   cs2 <= start2 ? 1 : 0;
        else if (cs2 == 21)  cs2 <= last2 ? 0 : 1;
        else                 cs2 <= cs2 + 1;
    end

    aes_round_ctrl #(.NUM_ROUNDS(1), .RCON_INIT(8'h01)) dut2 (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .InValidxSI(in_valid2), .InReadyxSO(in_ready2),
        .LoadxSO(load2), .StartxSO(start2), .IdlexSI(idle2), .ShiftRowsxSI(sr2),
        .LastRoundxSO(last2), .RoundxDO(round2), .RconxDO(rcon2), .BusyxSO(busy2),
        .DonexSO(done2), .OutAckxSI(out_ack2)
    );

    task automatic tick();
        @(posedge ClkxCI);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Reset values of every DUT1 output
    task automatic chk_reset(input string tag, input int k);
        chk({tag, ".ready"}, k, in_ready, 1);
        chk({tag, ".load"},  k, load,     0);
        chk({tag, ".start"}, k, start,    0);
        chk({tag, ".last"},  k, last,     0);
        chk({tag, ".busy"},  k, busy,     0);
        chk({tag, ".done"},  k, done,     0);
        chk({tag, ".round"}, k, round,    0);
        chk({tag, ".rcon"},  k, rcon,     0);
    endtask

    // One full 10-round block on DUT1, checked cycle by cycle against the
    // documented latency: Load@1, Start@2, round r starts at 3+21*(r-1),
    // final ShiftRows@212, Done from 213.
    task automatic run_block(input string tag);
        int r;
        in_valid = 1'b1;
        for (int k = 0; k <= DONE_LAST + 2; k++) begin
            if (k > 0) tick();
            if (k == 1) in_valid = 1'b0;
            out_ack = (k == DONE_LAST);
            chk({tag, ".load"},  k, load,     k == 1);
            chk({tag, ".start"}, k, start,    k == 2);
            chk({tag, ".last"},  k, last,     (k >= 192) && (k <= 212));
            chk({tag, ".busy"},  k, busy,     (k >= 1) && (k <= 212));
            chk({tag, ".done"},  k, done,     (k >= 213) && (k <= DONE_LAST));
            chk({tag, ".ready"}, k, in_ready, (k == 0) || (k > DONE_LAST));
            if (k == 2) begin
                chk({tag, ".round"}, k, round, 1);
                chk({tag, ".rcon"},  k, rcon,  8'h01);
            end
            if ((k >= 3) && (k <= 212) && ((k - 3) % 21 == 0)) begin
                r = (k - 3) / 21;
                chk({tag, ".round"}, k, round, r + 1);
                chk({tag, ".rcon"},  k, rcon,  rcon_tbl[r]);
            end
            if (k == 3)   chk({tag, ".cfsm_s1"}, k, cs, 1);
            if (k == 213) begin
                chk({tag, ".cfsm_idle"}, k, cs, 0);
                chk({tag, ".round_hold"}, k, round, 10);
                chk({tag, ".rcon_hold"}, k, rcon, 8'h36);
            end
            if (k == DONE_LAST + 1) begin
                chk({tag, ".round_clr"}, k, round, 0);
                chk({tag, ".rcon_clr"},  k, rcon,  0);
            end
        end
        out_ack = 1'b0;
    endtask

    initial begin
        // 1. Reset and idle
        #1;
        chk_reset("rst_async", 0);
        tick();
        tick();
        RstxBI = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            sr_force = (k == 2);
            chk_reset("idle", k);
        end
        sr_force = 1'b0;
        tick();
        chk_reset("sr_ignored", 5);

        // 2/3/4. Full block, latency, Rcon sequence, last-round window, done
        run_block("blk");

        // 5. Abort mid-block at cycle 100 (round 5)
        in_valid = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) tick();
            if (k == 1) in_valid = 1'b0;
        end
        chk("abort.round5", 100, round, 5);
        chk("abort.busy",   100, busy,  1);
        RstxBI = 1'b0;
        #1;
        chk_reset("abort", 100);
        chk("abort.cfsm_idle", 100, cs, 0);
        tick();
        tick();
        RstxBI = 1'b1;
        tick();
        tick();
        run_block("rerun");

        // 6. Single round, host keeps InValid high back-to-back
        in_valid2 = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            if (k > 0) tick();
            chk("nr1.load",  k, load2,     (k == 1) || (k == 26));
            chk("nr1.start", k, start2,    k == 2);
            chk("nr1.last",  k, last2,     (k >= 2) && (k <= 23));
            chk("nr1.done",  k, done2,     k == 24);
            chk("nr1.ready", k, in_ready2, (k == 0) || (k == 25));
            if ((k >= 2) && (k <= 23)) chk("nr1.round", k, round2, 1);
            if (k == 24) chk("nr1.cfsm_idle", k, cs2, 0);
        end
        in_valid2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
